// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns field-level requests into 32-bit words and
// writes them to sequential instruction-memory addresses through one write port.
module instr_encoder #(
  parameter int              DEPTH     = 256,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_class,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [20:0]                in_imm,
  input  logic                       clear,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ready,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CLASS = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                 state, state_next;
  logic [PTR_W-1:0]       ptr;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            word_p1;
  logic                   err_p1;
  logic [1:0]             err_code_p1;

  logic signed [20:0]     imm_s;
  logic [31:0]            enc_word;
  logic [1:0]             enc_err;
  logic                   hs, accept, reject, wr_done;

  function automatic logic fits12(input logic signed [20:0] v);
    return (v >= -21'sd2048) && (v <= 21'sd2047);
  endfunction

  function automatic logic fits13(input logic signed [20:0] v);
    return (v >= -21'sd4096) && (v <= 21'sd4095);
  endfunction

  assign imm_s = in_imm;

  always_comb begin
    enc_word = '0;
    enc_err  = ERR_NONE;
    case (in_class)
      3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd1, 3'd2, 3'd6: begin
        if (!fits12(imm_s)) enc_err = ERR_RANGE;
        if (in_class == 3'd1)
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else if (in_class == 3'd2)
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        else
          enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      end
      3'd3: begin
        if (!fits12(imm_s)) enc_err = ERR_RANGE;
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      end
      3'd4: begin
        if (!fits13(imm_s))  enc_err = ERR_RANGE;
        else if (in_imm[0])  enc_err = ERR_ALIGN;
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
      end
      3'd5: begin
        if (in_imm[0]) enc_err = ERR_ALIGN;
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      end
      default: enc_err = ERR_CLASS;
    endcase
  end

  // A clear cycle never counts as a transfer even though in_ready stays up.
  assign in_ready = (state == IDLE) && !full;
  assign hs       = in_valid && in_ready && !clear;
  assign accept   = hs && (enc_err == ERR_NONE);
  assign reject   = hs && (enc_err != ERR_NONE);
  assign wr_done  = (state == WRITE) && mem_ready && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)    state_next = WRITE;
        WRITE:   if (mem_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Stage p1: registered word, pointer/occupancy and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_p1     <= '0;
      ptr         <= '0;
      cnt         <= '0;
      err_p1      <= 1'b0;
      err_code_p1 <= ERR_NONE;
    end else begin
      err_p1      <= reject;
      err_code_p1 <= reject ? enc_err : ERR_NONE;
      if (accept) word_p1 <= enc_word;
      if (clear) begin
        ptr <= '0;
        cnt <= '0;
      end else if (wr_done) begin
        ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign mem_we    = (state == WRITE);
  assign mem_wdata = word_p1;
  assign mem_addr  = BASE_ADDR + {{(ADDR_W-PTR_W-2){1'b0}}, ptr, 2'b00};
  assign full      = (cnt == CNT_W'(DEPTH));
  assign count     = cnt;
  assign err       = err_p1;
  assign err_code  = err_code_p1;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes field-level instruction requests into 32-bit RV32I words and streams them into instruction memory through a single write port. It is the inverse of the opcode-to-control decoder and covers the same instruction classes: R-type, OP-IMM, LOAD, STORE, BRANCH, JAL and JALR. It sits between the testbench or boot loader and the instruction memory write port. A sequential address pointer places each encoded word at the next word address, and an occupancy counter tracks how many words have been written.

## Interface
- DEPTH, 256: number of instruction words the pointer may address; pointer range is 0..DEPTH-1.
- ADDR_W, 32: width of the memory byte address.
- BASE_ADDR, 0: byte address of word 0; must be word-aligned.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder accepts a request this cycle.
- in_class  in  3  instruction class: 0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; used by R only.
- in_imm  in  21  signed immediate, byte offset.
- clear  in  1  synchronous pulse: zero pointer and count.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  byte address, equal to BASE_ADDR + 4*ptr.
- mem_wdata  out  32  encoded word.
- mem_ready  in  1  memory accepts the write while mem_we is high.
- full  out  1  count == DEPTH.
- count  out  clog2(DEPTH)+1  number of words written since reset or clear.
- err  out  1  one-cycle pulse: the accepted request was rejected.
- err_code  out  2  reason for rejection, valid with err: 1 illegal class, 2 immediate out of range, 3 immediate misaligned.

## Operation
- States:
  - IDLE: in_ready = !full.
  - WRITE: mem_we = 1 and in_ready = 0.
- A handshake occurs when in_valid && in_ready. On a handshake, the request is validated and encoded into a registered word.
  - Valid request: the word is registered, and the state moves IDLE -> WRITE.
  - Rejected request: the state stays IDLE, err = 1 and err_code is set for one cycle, and nothing is written.
- WRITE -> IDLE on the cycle mem_ready = 1. On that edge, ptr and count each increment by 1.
- Opcodes by class:
  - R: 0110011
  - OP-IMM: 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - JAL: 1101111
  - JALR: 1100111
- Bit layouts:
  - R: {f7, rs2, rs1, f3, rd, op}.
  - OP-IMM and LOAD: {imm[11:0], rs1, f3, rd, op}.
  - JALR: same layout as OP-IMM, with f3 forced to 000.
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Fields a class does not use are ignored.
- Immediate checks (in_imm is two's complement):
  - OP-IMM, LOAD, STORE, JALR: range -2048..2047.
  - BRANCH: range -4096..4095, and imm[0] must be 0.
  - JAL: imm[0] must be 0; the full 21-bit range is legal.
- Error priority: illegal class > out of range > misaligned.
- When count reaches DEPTH, full = 1 and ptr has wrapped to 0. No further requests are accepted until clear.
- clear has priority over everything else:
  - ptr = 0 and count = 0.
  - If in WRITE, the pending write is aborted, mem_we is 0 on the next cycle, and the state returns to IDLE.
  - A handshake presented in the same cycle as clear is ignored. in_ready is still driven, so the requester must treat a cycle with clear as no transfer.

## Timing
- Reset values:
  - State IDLE, ptr 0, count 0.
  - mem_we 0, mem_wdata 0, mem_addr BASE_ADDR.
  - err 0, err_code 0, full 0.
  - in_ready 1 after reset deasserts.
- Asserting rst mid-write drops mem_we immediately and discards the word.
- Latency: a handshake at edge N gives mem_we = 1 with stable mem_wdata and mem_addr from N+1.
  - These outputs hold unchanged while mem_ready = 0.
  - A rejected request raises err only during cycle N+1.
- Throughput is at most one word per 2 cycles, since there is no accept while in WRITE.
- count and full update on the same edge as the accepted write.
- in_ready is a function of state and full only; it does not depend on in_valid or mem_ready.

## Test plan
- R request, class 0, rd 3, rs1 1, rs2 2, f3 0, f7 0 -> mem_wdata 0x002081B3 at mem_addr 0, count 1.
- LOAD request, rd 5, rs1 2, f3 2, imm -4 -> 0xFFC12283 at address 4. Then BRANCH, rs1 1, rs2 2, f3 0, imm 8 -> 0x00208463 at address 8.
- JAL request, rd 1, imm 2048 -> 0x001000EF. JALR request with f3 = 7 -> encoded f3 is 000.
- Rejections, each with no mem_we and count unchanged:
  - BRANCH imm 7 -> err_code 3.
  - STORE imm 2048 -> err_code 2.
  - class 7 -> err_code 1.
- DEPTH = 4, with mem_ready held low for 3 cycles -> word, address and mem_we hold steady. After the 4th write, full = 1 and in_ready = 0. clear -> count 0, and the next write goes to BASE_ADDR.
- rst asserted while in WRITE -> mem_we low immediately and count 0. After release, the first write goes to address 0.
